// File: rtl/bcd_hour_cnt.sv
// BCD hour counter: 24-hour internal state with up/down counting, load, and 12/24-hour display.
// Optional hour alarm (al_ld/al_h/al_hit) is built when HOUR_ALARM_EN is defined.
module bcd_hour_cnt #(
    parameter logic [7:0] INIT_H = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       mode12,
    input  logic       ld,
    input  logic [7:0] ld_h,
    output logic [3:0] qh,
    output logic [3:0] ql,
    output logic       pm,
    output logic       carry,
    output logic       err
`ifdef HOUR_ALARM_EN
    ,
    input  logic       al_ld,
    input  logic [7:0] al_h,
    output logic       al_hit
`endif
);

    logic [7:0] r_h24;
    logic       r_err;
    logic [7:0] w_inc;
    logic [7:0] w_dec;
    logic [7:0] w_count;
    logic       w_ld_legal;
    logic [4:0] w_bin;
    logic [4:0] w_d12;
    logic [7:0] w_disp;

    function automatic logic is_legal(input logic [7:0] v);
        return (v[7:4] <= 4'd2) && (v[3:0] <= 4'd9) && (v <= 8'h23);
    endfunction

    assign w_ld_legal = is_legal(ld_h);

    always_comb begin
        w_inc = r_h24;
        if (r_h24 == 8'h23)
            w_inc = 8'h00;
        else if (r_h24[3:0] == 4'd9)
            w_inc = {r_h24[7:4] + 4'd1, 4'd0};
        else
            w_inc = {r_h24[7:4], r_h24[3:0] + 4'd1};
    end

    always_comb begin
        w_dec = r_h24;
        if (r_h24 == 8'h00)
            w_dec = 8'h23;
        else if (r_h24[3:0] == 4'd0)
            w_dec = {r_h24[7:4] - 4'd1, 4'd9};
        else
            w_dec = {r_h24[7:4], r_h24[3:0] - 4'd1};
    end

    assign w_count = up ? w_inc : w_dec;

    // A rejected load leaves the hour untouched; load always beats count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h24 <= INIT_H;
            r_err <= 1'b0;
        end else begin
            r_err <= ld & ~w_ld_legal;
            if (ld) begin
                if (w_ld_legal)
                    r_h24 <= ld_h;
            end else if (en) begin
                r_h24 <= w_count;
            end
        end
    end

    // Binary view of the hour makes the 12-hour remap a plain subtraction.
    assign w_bin = 5'(r_h24[7:4]) * 5'd10 + 5'(r_h24[3:0]);
    assign w_d12 = w_bin - 5'd12;

    always_comb begin
        w_disp = r_h24;
        if (mode12) begin
            if (w_bin == 5'd0)
                w_disp = 8'h12;
            else if (w_bin <= 5'd12)
                w_disp = r_h24;
            else if (w_d12 >= 5'd10)
                w_disp = {4'd1, 4'(w_d12 - 5'd10)};
            else
                w_disp = {4'd0, w_d12[3:0]};
        end
    end

    assign qh    = w_disp[7:4];
    assign ql    = w_disp[3:0];
    assign pm    = (w_bin >= 5'd12);
    assign carry = en & ~ld & ((up & (r_h24 == 8'h23)) | (~up & (r_h24 == 8'h00)));
    assign err   = r_err;

`ifdef HOUR_ALARM_EN
    logic [7:0] r_al_h;
    logic       r_al_hit;

    // Only a counting step onto the alarm hour fires; a load never does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_al_h   <= 8'h00;
            r_al_hit <= 1'b0;
        end else begin
            if (al_ld && is_legal(al_h))
                r_al_h <= al_h;
            r_al_hit <= en & ~ld & (w_count == r_al_h);
        end
    end

    assign al_hit = r_al_hit;
`endif

endmodule

// File: tb/tb_bcd_hour_cnt.sv
// Self-checking bench for bcd_hour_cnt: integer-hour reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_bcd_hour_cnt;
    localparam logic [7:0] INIT = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       mode12 = 1'b0;
    logic       ld = 1'b0;
    logic [7:0] ld_h = 8'h00;
    logic [3:0] qh;
    logic [3:0] ql;
    logic       pm;
    logic       carry;
    logic       err;
`ifdef HOUR_ALARM_EN
    logic       al_ld = 1'b0;
    logic [7:0] al_h = 8'h00;
    logic       al_hit;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    bcd_hour_cnt #(.INIT_H(INIT)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode12(mode12),
        .ld(ld), .ld_h(ld_h), .qh(qh), .ql(ql), .pm(pm), .carry(carry), .err(err)
`ifdef HOUR_ALARM_EN
        , .al_ld(al_ld), .al_h(al_h), .al_hit(al_hit)
`endif
    );

    always #5 clk = ~clk;

    function automatic int bcd2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    function automatic bit legal(input logic [7:0] v);
        return (v[7:4] <= 2) && (v[3:0] <= 9) && (bcd2i(v) <= 23);
    endfunction

    function automatic int shown(input int h, input bit m12);
        if (!m12) return h;
        if (h % 12 == 0) return 12;
        return h % 12;
    endfunction

    function automatic int stepped(input int h, input bit dir_up);
        return dir_up ? (h + 1) % 24 : (h + 23) % 24;
    endfunction

    // Reference model: the hour as an integer 0..23
    int m_h;
    bit m_err;
`ifdef HOUR_ALARM_EN
    int m_al;
    bit m_hit;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h   <= bcd2i(INIT);
            m_err <= 1'b0;
`ifdef HOUR_ALARM_EN
            m_al  <= 0;
            m_hit <= 1'b0;
`endif
        end else begin
            m_err <= ld && !legal(ld_h);
            if (ld) begin
                if (legal(ld_h)) m_h <= bcd2i(ld_h);
            end else if (en) begin
                m_h <= stepped(m_h, up);
            end
`ifdef HOUR_ALARM_EN
            if (al_ld && legal(al_h)) m_al <= bcd2i(al_h);
            m_hit <= en && !ld && (stepped(m_h, up) == m_al);
`endif
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("cyc_disp", {qh, ql}, i2bcd(shown(m_h, mode12)));
            chk("cyc_pm", 8'(pm), 8'(m_h >= 12));
            chk("cyc_carry", 8'(carry),
                8'(en && !ld && ((up && m_h == 23) || (!up && m_h == 0))));
            chk("cyc_err", 8'(err), 8'(m_err));
`ifdef HOUR_ALARM_EN
            chk("cyc_al_hit", 8'(al_hit), 8'(m_hit));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        ld = 1'b1;
        ld_h = v;
        cyc();
        ld = 1'b0;
    endtask

    logic [7:0] m12_in  [4] = '{8'h00, 8'h12, 8'h13, 8'h23};
    logic [7:0] m12_out [4] = '{8'h12, 8'h12, 8'h01, 8'h11};
    bit         m12_pm  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_disp", {qh, ql}, 8'h00);
        chk("rst_err", 8'(err), 8'h00);
        repeat (2) cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("post_rst_pm", 8'(pm), 8'h00);
        chk("post_rst_carry", 8'(carry), 8'h00);

        // Full upward wrap
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 24; i++) begin
            chk("seq_disp", {qh, ql}, i2bcd(i));
            chk("seq_carry", 8'(carry), 8'(i == 23));
            $display("[TB] up step %0d: disp %h carry %0b", i, {qh, ql}, carry);
            cyc();
        end
        chk("wrap_disp", {qh, ql}, 8'h00);

        // Downward wrap 00 -> 23
        up = 1'b0;
        #1 chk("down_carry", 8'(carry), 8'h01);
        cyc();
        en = 1'b0;
        chk("down_disp", {qh, ql}, 8'h23);
        chk("down_pm", 8'(pm), 8'h01);
        $display("[TB] down wrap: disp %h pm %0b", {qh, ql}, pm);

        // Legal and illegal loads
        load(8'h19);
        chk("ld19_disp", {qh, ql}, 8'h19);
        chk("ld19_err", 8'(err), 8'h00);
        load(8'h24);
        chk("ld24_disp", {qh, ql}, 8'h19);
        chk("ld24_err", 8'(err), 8'h01);
        cyc();
        chk("ld24_err_clr", 8'(err), 8'h00);
        load(8'h1A);
        chk("ld1A_disp", {qh, ql}, 8'h19);
        chk("ld1A_err", 8'(err), 8'h01);
        cyc();
        chk("ld1A_err_clr", 8'(err), 8'h00);
        $display("[TB] illegal loads: disp %h", {qh, ql});

        // 12-hour display map, zero-latency mode toggle
        for (int i = 0; i < 4; i++) begin
            mode12 = 1'b1;
            load(m12_in[i]);
            chk("m12_disp", {qh, ql}, m12_out[i]);
            chk("m12_pm", 8'(pm), 8'(m12_pm[i]));
            mode12 = 1'b0;
            #1 chk("m24_disp", {qh, ql}, m12_in[i]);
            chk("m24_pm", 8'(pm), 8'(m12_pm[i]));
            $display("[TB] mode12 h24 %h -> %h pm %0b", m12_in[i], m12_out[i], m12_pm[i]);
        end

        // Asynchronous reset between edges while counting
        load(8'h15);
        en = 1'b1;
        up = 1'b1;
        cyc();
        chk("pre_rst_disp", {qh, ql}, 8'h16);
        rst = 1'b1;
        #1 chk("async_rst_disp", {qh, ql}, INIT);
        #1 rst = 1'b0;
        cyc();
        chk("resume_disp", {qh, ql}, 8'h01);
        $display("[TB] async reset then resume: disp %h", {qh, ql});

        // Load beats count, carry suppressed
        en = 1'b0;
        load(8'h23);
        en = 1'b1;
        ld = 1'b1;
        ld_h = 8'h05;
        #1 chk("ld_en_carry", 8'(carry), 8'h00);
        cyc();
        ld = 1'b0;
        en = 1'b0;
        chk("ld_en_disp", {qh, ql}, 8'h05);
        $display("[TB] load vs count: disp %h", {qh, ql});

`ifdef HOUR_ALARM_EN
        al_ld = 1'b1;
        al_h = 8'h07;
        load(8'h06);
        al_ld = 1'b0;
        chk("al_idle", 8'(al_hit), 8'h00);
        en = 1'b1;
        up = 1'b1;
        cyc();
        en = 1'b0;
        chk("al_cnt_disp", {qh, ql}, 8'h07);
        chk("al_hit_pulse", 8'(al_hit), 8'h01);
        cyc();
        chk("al_hit_clr", 8'(al_hit), 8'h00);
        load(8'h06);
        load(8'h07);
        chk("al_ld_nohit", 8'(al_hit), 8'h00);
        al_ld = 1'b1;
        al_h = 8'h25;
        cyc();
        al_ld = 1'b0;
        chk("al_bad_err", 8'(err), 8'h00);
        load(8'h06);
        en = 1'b1;
        cyc();
        en = 1'b0;
        chk("al_kept_hit", 8'(al_hit), 8'h01);
        $display("[TB] alarm: al_hit %0b", al_hit);
`endif

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_hour_cnt.md
BCD_HOUR_CNT -- requirements
Module: bcd_hour_cnt

Interface
REQ-001 SHALL have parameter INIT_H, default 8'h00: BCD 24-hour value loaded at reset; legal range 00..23.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port en, input, 1 bit: count tick; one step per clk edge while high.
REQ-005 SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port mode12, input, 1 bit: display mode; 1 = 12-hour, 0 = 24-hour.
REQ-007 SHALL have port ld, input, 1 bit: synchronous load strobe.
REQ-008 SHALL have port ld_h, input, 8 bits: BCD 24-hour load value; [7:4] is tens, [3:0] is ones.
REQ-009 SHALL have port qh, output, 4 bits: displayed tens digit.
REQ-010 SHALL have port ql, output, 4 bits: displayed ones digit.
REQ-011 SHALL have port pm, output, 1 bit: 1 when internal hour >= 12, in either mode.
REQ-012 SHALL have port carry, output, 1 bit: terminal-count flag for cascading.
REQ-013 SHALL have port err, output, 1 bit: load-rejected flag.

Function
REQ-014 SHALL hold one internal BCD 24-hour state h24 (00..23); every output derives from h24.
REQ-015 SHALL apply update priority: rst, then ld, then en; ld and en in the same cycle performs the load only.
REQ-016 SHALL increment h24 on en=1, up=1, with ones 9->0 plus tens+1, and 23->00.
REQ-017 SHALL decrement h24 on en=1, up=0, with ones 0->9 plus tens-1, and 00->23.
REQ-018 SHALL hold h24 when en=0 and ld=0.
REQ-019 SHALL load h24 from ld_h when ld=1 and ld_h is legal: tens<=2, ones<=9, value<=23.
REQ-020 SHALL ignore an illegal ld_h, leaving h24 unchanged, and drive err=1 for exactly the following cycle; err=0 otherwise.
REQ-021 SHALL make carry combinational: carry = en & ~ld & ((up & h24==23) | (~up & h24==00)).
REQ-022 SHALL drive {qh,ql}=h24 when mode12=0.
REQ-023 SHALL map h24 for display when mode12=1: 00->12, 01..12 unchanged, 13..23 -> h24-12 in BCD.
REQ-024 SHALL treat mode12 as display-only: toggling it never alters h24, carry or pm; display changes in the same cycle (0 latency).
REQ-025 SHALL never let h24 hold a non-BCD value or a value above 23.

Reset
REQ-026 SHALL on rst=1 immediately set h24=INIT_H and err=0, independent of clk.
REQ-027 SHALL after reset show outputs {qh,ql}=INIT_H (or its 12-hour map when mode12=1), pm per INIT_H, and carry=0 unless en is high with a terminal value.
REQ-028 SHALL abandon a load or count in progress when rst asserts mid-cycle; no partial update survives.
REQ-029 SHALL resume counting on the first clk edge after rst deasserts.

Configuration
REQ-030 SHALL support the macro HOUR_ALARM_EN.
REQ-031 SHALL, with HOUR_ALARM_EN defined, add input al_ld (1 bit), input al_h (8 bits, BCD), and output al_hit (1 bit).
REQ-032 SHALL, with HOUR_ALARM_EN defined, capture a legal al_h on al_ld into an alarm register (reset 8'h00) and ignore an illegal al_h; err does not fire for a rejected al_h.
REQ-033 SHALL, with HOUR_ALARM_EN defined, pulse al_hit for one cycle after any edge where en (not ld) moves h24 onto the alarm value.
REQ-034 SHALL, with HOUR_ALARM_EN undefined, omit those ports and all alarm logic.

Verification
REQ-035 Bench SHALL cover: INIT_H=8'h00, en=1, up=1 for 24 edges -> sequence 00..23 then 00; carry=1 only while h24=23.
REQ-036 Bench SHALL cover: h24=00, en=1, up=0, one edge -> h24=23, carry=1 in the cycle before that edge, pm=1 after it.
REQ-037 Bench SHALL cover: ld_h=8'h19 -> h24=19; ld_h=8'h24 and then 8'h1A -> h24 stays 19, err=1 for one cycle each time.
REQ-038 Bench SHALL cover: mode12=1 with h24=00, 12, 13, 23 -> displays 12/pm0, 12/pm1, 01/pm1, 11/pm1.
REQ-039 Bench SHALL cover: rst pulsed between clk edges with en=1 -> h24=INIT_H immediately; ld=1 with en=1 -> load wins, carry=0.
REQ-040 Bench SHALL cover, with HOUR_ALARM_EN: alarm 07, count 06->07 -> al_hit=1 for one cycle; ld to 07 -> al_hit stays 0.
